// File: rtl/keypad_pkg.sv
// Shared types, sizes and image helpers for the 5x4 keypad scanner.
// Imported by keypad_frame_debounce and keypad_scan_ctrl.
package keypad_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 20;
    localparam int CODE_W   = 5;

    typedef enum logic [1:0] {
        DRIVE,
        SAMPLE,
        FRAME_END
    } scan_state_t;

    // Number of pressed keys in an image.
    function automatic logic [CODE_W-1:0] key_count(
        input logic [NUM_KEYS-1:0] img
    );
        logic [CODE_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + CODE_W'(img[i]);
        end
        return n;
    endfunction

    // Index of the lowest pressed key (row*4 + col); 0 when none.
    function automatic logic [CODE_W-1:0] key_encode(
        input logic [NUM_KEYS-1:0] img
    );
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (img[i]) begin
                c = CODE_W'(i);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debounce: counts identical consecutive frames and
// commits the image to key_map when the count reaches DEBOUNCE_SCANS.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_end,
    input  logic [NUM_KEYS-1:0] frame_img,
    output logic                commit,
    output logic [NUM_KEYS-1:0] key_map
);

    localparam logic [3:0] DEB      = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic [NUM_KEYS-1:0] prev_img;
    logic [3:0]          stable_cnt;
    logic                same;

    assign same = (frame_img == prev_img);

    // Commit only on the frame where the count reaches its target,
    // so a saturated stable image is never re-committed.
    assign commit = frame_end && same && (stable_cnt == DEB_LAST);

    // Stability counter, previous frame and committed image.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_img   <= '0;
            stable_cnt <= '0;
            key_map    <= '0;
        end else if (frame_end) begin
            prev_img <= frame_img;
            if (!same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != DEB) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
            if (commit) begin
                key_map <= frame_img;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 5x4 keypad row scanner with frame debounce and one event per press.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic                clk,
    input  logic                RSTN,
    input  logic [NUM_COLS-1:0] K_COL,
    output logic [NUM_ROWS-1:0] K_ROW,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic                multi_key,
    output logic [NUM_KEYS-1:0] key_map
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
        $error("DEBOUNCE_SCANS must be in 1..15");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
        $error("REPEAT_DELAY and REPEAT_RATE must be positive");
    end

    scan_state_t         state;
    scan_state_t         state_n;
    logic                run_q;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          row;
    logic [4:0]          base;
    logic [NUM_KEYS-1:0] frame_img;
    logic [NUM_COLS-1:0] col_m;
    logic [NUM_COLS-1:0] col_s;
    logic [NUM_COLS-1:0] col_hit;
    logic                sample_en;
    logic                frame_end;
    logic                commit;
    logic                fresh;
    logic                rpt_fire;

    // Two-flop synchronizer on the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= K_COL;
            col_s <= col_m;
        end
    end

    assign col_hit = ~col_s;
    assign base    = 5'(row * NUM_COLS);

    // FSM state register; run_q gives one idle cycle after reset.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state <= DRIVE;
            run_q <= 1'b0;
        end else begin
            state <= state_n;
            run_q <= 1'b1;
        end
    end

    // Next-state logic: settle, sample each row, then close the frame.
    always_comb begin
        state_n = state;
        if (run_q) begin
            unique case (state)
                DRIVE: begin
                    if (cnt == LAST) begin
                        state_n = SAMPLE;
                    end
                end
                SAMPLE: begin
                    state_n = (row == LAST_ROW) ? FRAME_END : DRIVE;
                end
                FRAME_END: begin
                    state_n = DRIVE;
                end
                default: begin
                    state_n = DRIVE;
                end
            endcase
        end
    end

    // FSM outputs: row drive and per-state strobes.
    always_comb begin
        K_ROW     = '1;
        sample_en = 1'b0;
        frame_end = 1'b0;
        if (run_q) begin
            K_ROW     = ~(NUM_ROWS'(1) << row);
            sample_en = (state == SAMPLE);
            frame_end = (state == FRAME_END);
        end
    end

    // Settle counter, row index and the raw frame image.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            cnt       <= '0;
            row       <= '0;
            frame_img <= '0;
        end else begin
            if (run_q && state == DRIVE) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
            if (sample_en) begin
                frame_img[base +: NUM_COLS] <= col_hit;
                if (row != LAST_ROW) begin
                    row <= row + 3'd1;
                end
            end
            if (frame_end) begin
                row <= '0;
            end
        end
    end

    keypad_frame_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (RSTN),
        .frame_end (frame_end),
        .frame_img (frame_img),
        .commit    (commit),
        .key_map   (key_map)
    );

    assign key_held  = (key_count(key_map) == CODE_W'(1));
    assign multi_key = (key_count(key_map) >  CODE_W'(1));

    // A press counts only when coming from an all-released image.
    assign fresh = commit
                && (key_count(key_map) == '0)
                && (key_count(frame_img) == CODE_W'(1));

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rpt_cnt;
    logic [15:0] rpt_nxt;
    logic        rpt_first;

    assign rpt_nxt  = rpt_cnt + 16'd1;
    assign rpt_fire = frame_end && !commit && key_held
                   && (rpt_first ? (rpt_nxt == 16'(REPEAT_RATE))
                                 : (rpt_nxt == 16'(REPEAT_DELAY)));

    // Frame counter for auto-repeat; restarts on every commit.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (commit) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (frame_end && key_held) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else begin
                rpt_cnt <= rpt_nxt;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Event output: pulse and code update together.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= fresh || rpt_fire;
            if (fresh) begin
                key_code <= key_encode(frame_img);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a 26-cycle frame.
// A keypad model drives K_COL from K_ROW and the pressed-key vector.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        RSTN;
    logic [3:0]  K_COL;
    logic [4:0]  K_ROW;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [19:0] key_map;

    logic [19:0] keys;
    int n_pass  = 0;
    int n_total = 0;
    int pc      = 0;
    int k       = 0;
    int base;

`ifdef KEYPAD_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .K_COL     (K_COL),
        .K_ROW     (K_ROW),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key),
        .key_map   (key_map)
    );

    always #5 clk = ~clk;

    always_comb begin
        K_COL = 4'hf;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!K_ROW[r] && keys[r*4+c]) K_COL[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) pc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic go(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_frame_start();
        logic [4:0] prev;
        bit found;
        found = 1'b0;
        prev  = K_ROW;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (prev !== 5'b11110 && K_ROW === 5'b11110) found = 1'b1;
            else prev = K_ROW;
        end
        k = 1;
        n_total++;
        if (!found) $display("FAIL frame_start got none within 80 cycles exp one");
        else n_pass++;
    endtask

    task automatic release_all();
        keys = '0;
        repeat (26 * 4) @(negedge clk);
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        n_total++; if (K_ROW !== 5'b11111) $display("FAIL rst_krow got %b exp 11111", K_ROW); else n_pass++;
        n_total++; if (key_code !== 5'd0) $display("FAIL rst_code got %0d exp 0", key_code); else n_pass++;
        n_total++; if (key_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", key_valid); else n_pass++;
        n_total++; if (key_map !== 20'h0) $display("FAIL rst_map got %h exp 00000", key_map); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL rst_held got %b exp 0", key_held); else n_pass++;
        n_total++; if (multi_key !== 1'b0) $display("FAIL rst_multi got %b exp 0", multi_key); else n_pass++;
        RSTN = 1'b1;
        k = 0;
        go(1);
        n_total++; if (K_ROW !== 5'b11110) $display("FAIL scan_r0_first got %b exp 11110", K_ROW); else n_pass++;
        go(5);
        n_total++; if (K_ROW !== 5'b11110) $display("FAIL scan_r0_last got %b exp 11110", K_ROW); else n_pass++;
        go(6);
        n_total++; if (K_ROW !== 5'b11101) $display("FAIL scan_r1_first got %b exp 11101", K_ROW); else n_pass++;
        go(10);
        n_total++; if (K_ROW !== 5'b11101) $display("FAIL scan_r1_last got %b exp 11101", K_ROW); else n_pass++;
        go(11);
        n_total++; if (K_ROW !== 5'b11011) $display("FAIL scan_r2_first got %b exp 11011", K_ROW); else n_pass++;
    endtask

    task automatic test_press();
        wait_frame_start();
        keys = 20'h00200;
        base = pc;
        go(78);
        n_total++; if (key_valid !== 1'b0) $display("FAIL press_early got %b exp 0", key_valid); else n_pass++;
        go(79);
        n_total++; if (key_valid !== 1'b1) $display("FAIL press_valid got %b exp 1", key_valid); else n_pass++;
        n_total++; if (key_code !== 5'd9) $display("FAIL press_code got %0d exp 9", key_code); else n_pass++;
        n_total++; if (key_held !== 1'b1) $display("FAIL press_held got %b exp 1", key_held); else n_pass++;
        n_total++; if (key_map !== 20'h00200) $display("FAIL press_map got %h exp 00200", key_map); else n_pass++;
        n_total++; if (multi_key !== 1'b0) $display("FAIL press_multi got %b exp 0", multi_key); else n_pass++;
        go(80);
        n_total++; if (key_valid !== 1'b0) $display("FAIL press_width got %b exp 0", key_valid); else n_pass++;
        go(81);
        n_total++; if (pc - base !== 1) $display("FAIL press_count got %0d exp 1", pc - base); else n_pass++;
    endtask

    task automatic test_bounce();
        release_all();
        wait_frame_start();
        base = pc;
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 20'h00200 : 20'h0;
            go(1 + 26 * (f + 1));
        end
        n_total++; if (pc - base !== 0) $display("FAIL bounce_quiet got %0d exp 0", pc - base); else n_pass++;
        keys = 20'h00200;
        go(234);
        n_total++; if (key_valid !== 1'b0) $display("FAIL bounce_early got %b exp 0", key_valid); else n_pass++;
        go(235);
        n_total++; if (key_valid !== 1'b1) $display("FAIL bounce_valid got %b exp 1", key_valid); else n_pass++;
        n_total++; if (key_code !== 5'd9) $display("FAIL bounce_code got %0d exp 9", key_code); else n_pass++;
        go(261);
        n_total++; if (pc - base !== 1) $display("FAIL bounce_count got %0d exp 1", pc - base); else n_pass++;
    endtask

    task automatic test_multi();
        release_all();
        wait_frame_start();
        base = pc;
        keys = 20'h80001;
        go(79);
        n_total++; if (multi_key !== 1'b1) $display("FAIL multi_flag got %b exp 1", multi_key); else n_pass++;
        n_total++; if (key_map !== 20'h80001) $display("FAIL multi_map got %h exp 80001", key_map); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL multi_held got %b exp 0", key_held); else n_pass++;
        n_total++; if (key_code !== 5'd9) $display("FAIL multi_code got %0d exp 9", key_code); else n_pass++;
        keys = 20'h80000;
        go(158);
        n_total++; if (key_map !== 20'h80000) $display("FAIL multi_one_map got %h exp 80000", key_map); else n_pass++;
        n_total++; if (multi_key !== 1'b0) $display("FAIL multi_one_flag got %b exp 0", multi_key); else n_pass++;
        n_total++; if (pc - base !== 0) $display("FAIL multi_no_event got %0d exp 0", pc - base); else n_pass++;
        keys = 20'h0;
        go(235);
        n_total++; if (key_map !== 20'h0) $display("FAIL multi_release got %h exp 00000", key_map); else n_pass++;
        keys = 20'h80000;
        go(313);
        n_total++; if (key_valid !== 1'b1) $display("FAIL multi_fresh_valid got %b exp 1", key_valid); else n_pass++;
        n_total++; if (key_code !== 5'd19) $display("FAIL multi_fresh_code got %0d exp 19", key_code); else n_pass++;
        go(315);
        n_total++; if (pc - base !== 1) $display("FAIL multi_count got %0d exp 1", pc - base); else n_pass++;
    endtask

    task automatic test_reset_mid();
        release_all();
        wait_frame_start();
        keys = 20'h00020;
        go(79);
        n_total++; if (key_code !== 5'd5) $display("FAIL mid_pre_code got %0d exp 5", key_code); else n_pass++;
        go(90);
        RSTN = 1'b0;
        go(91);
        n_total++; if (K_ROW !== 5'b11111) $display("FAIL mid_krow got %b exp 11111", K_ROW); else n_pass++;
        n_total++; if (key_code !== 5'd0) $display("FAIL mid_code got %0d exp 0", key_code); else n_pass++;
        n_total++; if (key_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", key_valid); else n_pass++;
        n_total++; if (key_map !== 20'h0) $display("FAIL mid_map got %h exp 00000", key_map); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL mid_held got %b exp 0", key_held); else n_pass++;
        n_total++; if (multi_key !== 1'b0) $display("FAIL mid_multi got %b exp 0", multi_key); else n_pass++;
        RSTN = 1'b1;
        base = pc;
        go(169);
        n_total++; if (key_valid !== 1'b0) $display("FAIL mid_early got %b exp 0", key_valid); else n_pass++;
        go(170);
        n_total++; if (key_valid !== 1'b1) $display("FAIL mid_valid_after got %b exp 1", key_valid); else n_pass++;
        n_total++; if (key_code !== 5'd5) $display("FAIL mid_code_after got %0d exp 5", key_code); else n_pass++;
        go(172);
        n_total++; if (pc - base !== 1) $display("FAIL mid_count got %0d exp 1", pc - base); else n_pass++;
    endtask

    task automatic test_back_to_back();
        release_all();
        wait_frame_start();
        keys = 20'h00080;
        base = pc;
        go(79);
        n_total++; if (key_valid !== 1'b1) $display("FAIL rpt_first got %b exp 1", key_valid); else n_pass++;
        n_total++; if (key_code !== 5'd7) $display("FAIL rpt_code got %0d exp 7", key_code); else n_pass++;
        go(157);
        n_total++; if (key_valid !== REP) $display("FAIL rpt_delay got %b exp %b", key_valid, REP); else n_pass++;
        go(158);
        n_total++; if (key_valid !== 1'b0) $display("FAIL rpt_width got %b exp 0", key_valid); else n_pass++;
        go(209);
        n_total++; if (key_valid !== REP) $display("FAIL rpt_rate1 got %b exp %b", key_valid, REP); else n_pass++;
        go(261);
        n_total++; if (key_valid !== REP) $display("FAIL rpt_rate2 got %b exp %b", key_valid, REP); else n_pass++;
        n_total++; if (key_code !== 5'd7) $display("FAIL rpt_code_last got %0d exp 7", key_code); else n_pass++;
        go(270);
        n_total++;
        if (pc - base !== (REP ? 4 : 1)) $display("FAIL rpt_count got %0d exp %0d", pc - base, REP ? 4 : 1);
        else n_pass++;
        keys = '0;
    endtask

    initial begin
        RSTN = 1'b0;
        keys = '0;
        test_reset();
        test_press();
        test_bounce();
        test_multi();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Row-scanning controller for the 5×4 matrix keypad on the board's K_ROW/K_COL pins. It drives one row low at a time, samples the columns and debounces the full 20-key image at frame level. It emits a single encoded key event per press, which feeds the same consumers as the switch/button debouncer.

## Interface
- SETTLE_CYCLES, 1000: cycles a row is held low before its columns are sampled; must be ≥ 3.
- DEBOUNCE_SCANS, 4: consecutive identical frames required after a change; range 1..15.
- REPEAT_DELAY, 50: frames a key must be held before the first auto-repeat (only with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 10: frames between auto-repeats (only with KEYPAD_REPEAT_EN).
- clk  in  1  system clock; single clock domain.
- RSTN  in  1  reset; synchronous, active-low.
- K_COL  in  4  keypad columns; active-low, asynchronous.
- K_ROW  out  5  row drive; exactly one bit low while scanning.
- key_code  out  5  code of the last event: row*4 + col, range 0..19.
- key_valid  out  1  one-cycle pulse per key event.
- key_held  out  1  the debounced image holds exactly one pressed key.
- multi_key  out  1  the debounced image holds two or more pressed keys.
- key_map  out  20  debounced image; bit row*4+col = 1 means pressed.

## Operation
- K_COL passes through a 2-flop synchronizer and is inverted, so 1 = pressed.
- FSM states:
  - DRIVE: K_ROW = ~(1<<row). Counter runs 0..SETTLE_CYCLES-1, then the FSM moves to SAMPLE.
  - SAMPLE: synchronized columns are written into frame_img[row*4 +: 4]. If row < 4, row increments and the FSM returns to DRIVE; otherwise it goes to FRAME_END.
  - FRAME_END: frame_img is compared with prev_img.
    - Equal: stable_cnt increments, saturating at DEBOUNCE_SCANS.
    - Different: stable_cnt = 0.
    - In both cases prev_img <= frame_img, row = 0, and the FSM returns to DRIVE.
- Debounce commit: on the FRAME_END where stable_cnt transitions to DEBOUNCE_SCANS, key_map <= frame_img (held in keypad_frame_debounce).
- Event rule at commit:
  - Old key_map popcount 0, new popcount 1: key_valid pulses and key_code is set to the pressed index.
  - Any commit with new popcount ≥ 2: multi_key = 1, no event, key_code unchanged.
  - New popcount 1 from old popcount ≥ 2: no event; a fresh press requires passing through an all-released commit.
- key_held and multi_key are decoded combinationally from the registered key_map and are therefore registered-equivalent.
- Reset, including mid-frame:
  - Next cycle: K_ROW = 5'b11111, key_code = 0, key_valid = 0, key_map = 0, key_held = 0, multi_key = 0.
  - FSM = DRIVE, row = 0, counters = 0, frame_img = 0, prev_img = 0, stable_cnt = 0.
  - Scanning resumes on the first cycle with RSTN = 1.

## Timing
- Row slot = SETTLE_CYCLES + 1 cycles. Frame = 5*(SETTLE_CYCLES+1) + 1 cycles.
- Press latency: a press stable from frame F is committed at the FRAME_END of frame F+DEBOUNCE_SCANS. key_valid is high the cycle after that FRAME_END, for exactly 1 cycle.
- Release latency is the same: the key_map bit clears DEBOUNCE_SCANS frames after the first frame that sees the key released.
- A press shorter than DEBOUNCE_SCANS+1 frames produces no event.
- key_code and key_valid update in the same cycle.

## Configuration
- KEYPAD_REPEAT_EN defined: while key_held = 1 and key_map is unchanged, a frame counter starts at commit.
  - key_valid re-pulses with the same key_code at frame REPEAT_DELAY, then every REPEAT_RATE frames after that.
  - The counter clears on any commit or reset.
- KEYPAD_REPEAT_EN undefined: no repeat logic exists; exactly one key_valid per press; REPEAT_* parameters are ignored.

## Structure
- Package keypad_pkg holds:
  - the state enum (DRIVE, SAMPLE, FRAME_END);
  - NUM_ROWS = 5, NUM_COLS = 4, NUM_KEYS = 20, CODE_W = 5;
  - the popcount/encode function used for key_code.
- Sub-module keypad_frame_debounce owns prev_img, stable_cnt, key_map and the commit strobe.
- The top level owns the FSM, the synchronizer, event decode and optional repeat.

## Test plan
Bench parameters: SETTLE_CYCLES = 4, DEBOUNCE_SCANS = 2, giving a 26-cycle frame.
- Reset: K_ROW = 11111 and all outputs 0. After RSTN rises, K_ROW shows 11110 for 5 cycles, then 11101, and so on.
- Key row 2 col 1 held from frame start: one key_valid with key_code = 9 at the FRAME_END of the 3rd frame + 1 cycle; key_held = 1; key_map = 20'h00200.
- Bounce: key toggled every frame for 6 frames, then stable. No key_valid until 3 stable frames, then exactly one pulse.
- Two keys (codes 0 and 19) pressed together: multi_key = 1, no key_valid, key_map = 20'h80001. Releasing one gives no event. Full release followed by pressing code 19 gives key_valid with code 19.
- RSTN low for 1 cycle mid-frame while key 5 is held: all outputs clear. A new event with code 5 follows 3 frames later.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY = 3, REPEAT_RATE = 2 and key 7 held: pulses at commit, then at +3 frames, +5, +7. Without the macro: a single pulse.
